// File: rtl/aes_key_schedule_ctrl.sv
// AES-128 key-expansion sequencer: drives a single-round key-gen stage
// NR times and keeps all round keys in a randomly readable register file.
module aes_key_schedule_ctrl #(
  parameter int NR      = 10,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [127:0] key_in,
  output logic         key_ready,
  output logic         busy,
  output logic         keys_valid,
  output logic         err,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out,
  output logic         kg_start,
  output logic [3:0]   kg_rc,
  output logic [127:0] kg_key,
  input  logic         kg_finished,
  input  logic [127:0] kg_keyout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GEN  = 2'd1;
  localparam logic [1:0] S_NEXT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int NK = NR + 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] TO_LAST = WW'(TIMEOUT - 1);
  localparam logic [3:0]    RC_LAST = 4'(NR - 1);

  logic [1:0]    state_q, state_d;
  logic [127:0]  cur_key_q, cur_key_d;
  logic [3:0]    rc_q, rc_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic          kv_q, kv_d;
  logic          err_q, err_d;
  logic [127:0]  rk_q [NK];

  logic          rk_we;
  logic [3:0]    rk_wa;
  logic [127:0]  rk_wd;

  always_comb begin
    state_d   = state_q;
    cur_key_d = cur_key_q;
    rc_d      = rc_q;
    wdog_d    = wdog_q;
    kv_d      = kv_q;
    err_d     = 1'b0;
    rk_we     = 1'b0;
    rk_wa     = 4'd0;
    rk_wd     = '0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (key_valid) begin
          rk_we     = 1'b1;
          rk_wa     = 4'd0;
          rk_wd     = key_in;
          cur_key_d = key_in;
          rc_d      = 4'd0;
          wdog_d    = '0;
          kv_d      = 1'b0;
          state_d   = S_GEN;
        end
      end
      S_GEN: begin
        // a result arriving on the timeout edge still counts
        if (kg_finished) begin
          rk_we     = 1'b1;
          rk_wa     = rc_q + 4'd1;
          rk_wd     = kg_keyout;
          cur_key_d = kg_keyout;
          wdog_d    = '0;
          state_d   = S_NEXT;
        end else if (wdog_q == TO_LAST) begin
          err_d   = 1'b1;
          wdog_d  = '0;
          state_d = S_IDLE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      S_NEXT: begin
        if (rc_q == RC_LAST) begin
          kv_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          rc_d    = rc_q + 4'd1;
          state_d = S_GEN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cur_key_q <= '0;
      rc_q      <= 4'd0;
      wdog_q    <= '0;
      kv_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_key_q <= cur_key_d;
      rc_q      <= rc_d;
      wdog_q    <= wdog_d;
      kv_q      <= kv_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NK; i++) rk_q[i] <= '0;
    end else begin
      for (int i = 0; i < NK; i++)
        if (rk_we && rk_wa == 4'(i)) rk_q[i] <= rk_wd;
    end
  end

  always_comb begin
    rk_out = '0;
    for (int i = 0; i < NK; i++)
      if (rk_idx == 4'(i)) rk_out = rk_q[i];
  end

  assign kg_start   = (state_q == S_GEN);
  assign kg_rc      = rc_q;
  assign kg_key     = cur_key_q;
  assign busy       = (state_q == S_GEN) || (state_q == S_NEXT);
  assign key_ready  = (state_q == S_IDLE) || (state_q == S_DONE);
  assign keys_valid = kv_q;
  assign err        = err_q;

endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
// Bench for aes_key_schedule_ctrl with a behavioural AES round-key stage
// and a queue of expected round keys.
module tb_aes_key_schedule_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_valid;
  logic [127:0] key_in;
  logic         key_ready, busy, keys_valid, err;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;
  logic         kg_start;
  logic [3:0]   kg_rc;
  logic [127:0] kg_key;
  logic         kg_finished;
  logic [127:0] kg_keyout;

  int total = 0;
  int bad   = 0;
  int errs  = 0;
  int low   = 0;
  logic prev_start = 1'b0;
  int lat   = 0;
  logic stall = 1'b0;
  int scnt;

  logic [127:0] expq [$];
  int           rcq  [$];

  localparam logic [127:0] KA   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KA1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] KA10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KZ1  = 128'h62636363626363636263636362636363;

  aes_key_schedule_ctrl dut (
    .clk(clk), .rst(rst),
    .key_valid(key_valid), .key_in(key_in),
    .key_ready(key_ready), .busy(busy),
    .keys_valid(keys_valid), .err(err),
    .rk_idx(rk_idx), .rk_out(rk_out),
    .kg_start(kg_start), .kg_rc(kg_rc), .kg_key(kg_key),
    .kg_finished(kg_finished), .kg_keyout(kg_keyout)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] p = a;
    logic [7:0] v = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gmul(p, p);
      v = gmul(v, p);
    end
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
             ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] kround(input logic [127:0] k, input logic [3:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    logic [7:0]  r = 8'h01;
    w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
    t = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    for (int i = 0; i < int'(rc); i++) r = xt(r);
    t[31:24] ^= r;
    w0 ^= t; w1 ^= w0; w2 ^= w1; w3 ^= w2;
    return {w0, w1, w2, w3};
  endfunction

  // stage model: result after 'lat' extra cycles of kg_start
  always @(posedge clk or posedge rst) begin
    if (rst) scnt <= 0;
    else if (!kg_start) scnt <= 0;
    else scnt <= scnt + 1;
  end
  assign kg_finished = kg_start && !stall && (scnt >= lat);
  assign kg_keyout   = kround(kg_key, kg_rc);

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (err) errs++;
    if (kg_start && !prev_start && rcq.size() > 0) begin
      int e;
      e = rcq.pop_front();
      chk("kg_rc", 128'(kg_rc), 128'(e));
      if (e != 0) chk("start_gap", 128'(low), 128'd1);
    end
    if (kg_start) low = 0;
    else low++;
    prev_start = kg_start;
  end

  task automatic load(input logic [127:0] k, input bit push);
    logic [127:0] kk;
    @(negedge clk);
    key_in = k;
    key_valid = 1'b1;
    @(posedge clk);
    #1 key_valid = 1'b0;
    if (push) begin
      kk = k;
      expq.push_back(kk);
      for (int r = 0; r < 10; r++) begin
        kk = kround(kk, 4'(r));
        expq.push_back(kk);
      end
    end
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    while (!keys_valid && n < 2000) begin
      @(posedge clk);
      #1 n++;
    end
    chk("kv_wait", 128'(keys_valid), 128'd1);
  endtask

  task automatic wait_rc(input int r);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(kg_start && kg_rc == 4'(r)) && n < 1000);
    chk("rc_wait", 128'(kg_start && kg_rc == 4'(r)), 128'd1);
  endtask

  task automatic check_keys();
    logic [127:0] e;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      rk_idx = 4'(i);
      #1;
      e = (expq.size() > 0) ? expq.pop_front() : 'x;
      chk($sformatf("rk%0d", i), rk_out, e);
    end
  endtask

  task automatic read_rk(input int i, output logic [127:0] v);
    @(negedge clk);
    rk_idx = 4'(i);
    #1 v = rk_out;
  endtask

  initial begin
    int n;
    logic [127:0] v;
    rst = 1'b1;
    key_valid = 1'b0;
    key_in = '0;
    rk_idx = 4'd0;
    #12;
    chk("rst_ready", 128'(key_ready), 128'd1);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_kv", 128'(keys_valid), 128'd0);
    chk("rst_err", 128'(err), 128'd0);
    chk("rst_start", 128'(kg_start), 128'd0);
    chk("rst_rk0", rk_out, 128'd0);
    @(negedge clk);
    rst = 1'b0;

    // FIPS-197 A.1 with single-cycle stage
    for (int r = 0; r < 10; r++) rcq.push_back(r);
    load(KA, 1'b1);
    chk("a1_busy", 128'(busy), 128'd1);
    chk("a1_ready", 128'(key_ready), 128'd0);
    wait_valid(n);
    chk("a1_latency", 128'(n), 128'd21);
    chk("a1_rcq_empty", 128'(rcq.size()), 128'd0);
    check_keys();
    read_rk(1, v);
    chk("a1_rk1", v, KA1);
    read_rk(10, v);
    chk("a1_rk10", v, KA10);
    chk("a1_noerr", 128'(errs), 128'd0);

    // key offered mid-run is dropped
    lat = 2;
    load(KA, 1'b1);
    wait_rc(4);
    chk("busy_ready", 128'(key_ready), 128'd0);
    chk("busy_busy", 128'(busy), 128'd1);
    key_in = 128'h00112233445566778899aabbccddeeff;
    key_valid = 1'b1;
    repeat (3) @(negedge clk);
    key_valid = 1'b0;
    wait_valid(n);
    check_keys();
    read_rk(10, v);
    chk("busy_rk10", v, KA10);

    // re-key from DONE with all-zero key
    lat = 0;
    load('0, 1'b1);
    chk("rekey_kv_drop", 128'(keys_valid), 128'd0);
    wait_valid(n);
    chk("rekey_latency", 128'(n), 128'd21);
    check_keys();
    read_rk(1, v);
    chk("rekey_rk1", v, KZ1);
    read_rk(12, v);
    chk("rekey_idx12", v, 128'd0);
    read_rk(15, v);
    chk("rekey_idx15", v, 128'd0);

    // watchdog timeout
    stall = 1'b1;
    load(KA, 1'b0);
    n = 0;
    while (!err && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    chk("to_cycles", 128'(n), 128'd64);
    chk("to_busy", 128'(busy), 128'd0);
    chk("to_ready", 128'(key_ready), 128'd1);
    chk("to_kv", 128'(keys_valid), 128'd0);
    @(posedge clk);
    #1 chk("to_err_pulse", 128'(err), 128'd0);
    stall = 1'b0;
    read_rk(0, v);
    chk("to_rk0", v, KA);
    read_rk(1, v);
    chk("to_rk1_kept", v, KZ1);
    chk("to_errs", 128'(errs), 128'd1);

    // asynchronous reset during round 6
    load(KA, 1'b0);
    wait_rc(6);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 128'(busy), 128'd0);
    chk("arst_ready", 128'(key_ready), 128'd1);
    chk("arst_start", 128'(kg_start), 128'd0);
    chk("arst_kv", 128'(keys_valid), 128'd0);
    chk("arst_rc", 128'(kg_rc), 128'd0);
    chk("arst_key", kg_key, 128'd0);
    for (int i = 0; i < 16; i++) begin
      rk_idx = 4'(i);
      #0.1;
      chk($sformatf("arst_rk%0d", i), rk_out, 128'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    load(KA, 1'b1);
    wait_valid(n);
    chk("arst_latency", 128'(n), 128'd21);
    check_keys();
    chk("final_errs", 128'(errs), 128'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_key_schedule_ctrl.md
Name: aes_key_schedule_ctrl

Overview:
- Sequencer for the AES-128 key expansion. It drives the single-round key-generation stage (start/rc/key in, finished/keyout out) ten times and feeds each output key back as the next input.
- It stores all 11 round keys in a register file. The cipher round datapath reads them through a random-access read port.
- It sits between the key-load interface of the AES peripheral and the round datapath.

Parameters:
- NR, 10, number of expansion rounds. Fixed for AES-128. The rc field is 4 bits.
- TIMEOUT, 64, maximum cycles to wait for kg_finished in one round before an error is flagged.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- key_valid  input  1  cipher key present on key_in.
- key_in  input  128  cipher key. Bit 127 is byte 0 MSB.
- key_ready  output  1  high when a new key is accepted (IDLE or DONE).
- busy  output  1  expansion in progress.
- keys_valid  output  1  all 11 round keys are stored and consistent.
- err  output  1  one-cycle pulse when a round times out.
- rk_idx  input  4  round-key read index, 0..10.
- rk_out  output  128  round key rk[rk_idx]. Combinational read.
- kg_start  output  1  start to the key-generation stage.
- kg_rc  output  4  round-constant index to the stage.
- kg_key  output  128  previous round key to the stage.
- kg_finished  input  1  stage result valid.
- kg_keyout  input  128  next round key from the stage.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; all rk[0..10]=0; cur_key=0; rc=0; wdog=0.
  - kg_start=0, busy=0, keys_valid=0, err=0, key_ready=1.
- States: IDLE, GEN, NEXT, DONE.
- Accept:
  - A key is accepted when key_valid && key_ready at a rising edge.
  - On that edge: rk[0]<=key_in, cur_key<=key_in, rc<=0, wdog<=0, keys_valid<=0, state<=GEN.
  - Accept is legal from IDLE and DONE. key_valid in GEN/NEXT is ignored and not queued.
- GEN:
  - kg_start=1, kg_key=cur_key, kg_rc=rc.
  - wdog increments every cycle.
  - When kg_finished=1 at an edge: rk[rc+1]<=kg_keyout, cur_key<=kg_keyout, wdog<=0, state<=NEXT.
  - kg_finished is sampled only in GEN.
- NEXT:
  - kg_start=0 for exactly one cycle, which re-arms the S-boxes.
  - If rc==NR-1: state<=DONE, keys_valid<=1.
  - Otherwise: rc<=rc+1, state<=GEN.
- DONE: keys_valid=1 and held until the next accept or reset. kg_start=0.
- Timeout:
  - In GEN, if wdog reaches TIMEOUT-1 without kg_finished: err=1 for one cycle, state<=IDLE, keys_valid stays 0.
  - rk entries already written keep their values.
  - If kg_finished and the timeout occur on the same edge, finished wins.
- Output decode:
  - busy = (state==GEN || state==NEXT).
  - key_ready = (state==IDLE || state==DONE).
- Outputs outside GEN:
  - kg_rc holds rc.
  - kg_key holds cur_key.
  - kg_start=0.
- Read port:
  - rk_out=rk[rk_idx] in every state, combinational, and reflects a write from the following cycle onward.
  - rk_idx values 11..15 return 0.
- Latency:
  - With the stage returning finished in the first GEN cycle, accept to keys_valid=1 is 2*NR+1 = 21 cycles.
  - In general it is sum over rounds of (GEN cycles + 1), plus 1.
- Re-key in DONE:
  - keys_valid drops on the accept edge.
  - rk[1..10] keep their old values until overwritten. Consumers must gate on keys_valid.
- Mid-operation reset: state, key store and outputs return to reset values immediately. Nothing is retained.

Test Plan:
- FIPS-197 A.1:
  - Stimulus: key_in=2b7e151628aed2a6abf7158809cf4f3c with the real stage attached.
  - Required: rk[1]=a0fafe1788542cb123a339392a6c7605, rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6, keys_valid after 21 cycles.
- kg_rc sequence:
  - Stimulus: monitor kg_rc in each GEN phase during one expansion.
  - Required: 0,1,...,9; kg_start low for exactly one cycle between rounds; err never pulses.
- Busy-time loads:
  - Stimulus: assert key_valid with a different key during round 4.
  - Required: ignored, key_ready=0, final rk[10] still matches the A.1 vector.
- Timeout:
  - Stimulus: tie kg_finished=0 with TIMEOUT=64.
  - Required: err pulses 64 cycles after entering GEN; state returns to IDLE; keys_valid=0; rk[0]=key.
- Async reset mid-run:
  - Stimulus: assert rst in round 6.
  - Required: all outputs at reset values before the next edge; rk_out=0 for all indices; a fresh load then completes correctly.
- Re-key from DONE:
  - Stimulus: load key all-zero after the A.1 run.
  - Required: keys_valid falls on accept and rises 21 cycles later; rk[1]=62636363626363636263636362636363; rk_idx=12 returns 0.
